// File: rtl/heaa_mon_pkg.sv
// heaa_err_monitor shared types and constants.
// FSM state enum, ED width helper, default parameters.
package heaa_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mon_state_t;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_P     = 7;
  localparam int unsigned DEF_CW    = 16;
  localparam int unsigned DEF_ACC_W = 32;

  function automatic int unsigned ed_width(
    input int unsigned n
  );
    return n + 1;
  endfunction

endpackage

// File: rtl/heaa_err_monitor_ed_calc.sv
// heaa_ed_calc: approx (OR lower part) vs exact sum.
// Purely combinational; emits |approx - exact|.
module heaa_ed_calc
  import heaa_mon_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int P = DEF_P
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N:0]   ed
);

  logic [N:0] approx;
  logic [N:0] exact;
  logic       c;

  // OR lower part, carry from top lower bit pair
  always_comb begin
    approx = '0;
    for (int i = 0; i < P - 1; i++) begin
      approx[i] = x[i] | y[i];
    end
    c = x[P-1] & y[P-1];
    approx[P-1] = x[P-1] ^ y[P-1];
    approx[N:P] = {1'b0, x[N-1:P]}
                + {1'b0, y[N-1:P]}
                + (N-P+1)'(c);
  end

  assign exact = {1'b0, x} + {1'b0, y};

  // absolute difference
  always_comb begin
    if (approx > exact) ed = approx - exact;
    else                ed = exact - approx;
  end

endmodule

// File: rtl/heaa_err_monitor.sv
// heaa_err_monitor: streaming approx-adder error stats.
// HEAA_MON_SAT_EN: saturate sum_ed instead of wrapping.
module heaa_err_monitor
  import heaa_mon_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int P     = DEF_P,
  parameter int CW    = DEF_CW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N:0]       max_ed
);

  localparam int EDW = int'(ed_width(N));

  mon_state_t state_q, state_d;

  logic [CW-1:0]  cnt;
  logic [CW-1:0]  nsamp;
  logic           acc;
  logic           last;
  logic           start_acc;
  logic [N-1:0]   x1, y1;
  logic           v1, v2;
  logic [EDW-1:0] ed_c, ed2;
  logic [ACC_W-1:0] sum_nx;

  assign start_acc = start &&
    (state_q == IDLE || state_q == DONE);
  assign in_ready = (state_q == RUN) && (cnt < nsamp);
  assign acc  = in_valid & in_ready;
  assign last = acc && (cnt == nsamp - CW'(1));
  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (num_samples == '0) state_d = DONE;
          else                   state_d = RUN;
        end
      end
      RUN:   if (last) state_d = DRAIN;
      DRAIN: if (!v1 && !v2) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // run length capture and accepted count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      nsamp <= '0;
    end else if (start_acc) begin
      cnt   <= '0;
      nsamp <= num_samples;
    end else if (acc) begin
      cnt   <= cnt + CW'(1);
    end
  end

  // S1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      y1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= acc;
      if (acc) begin
        x1 <= x;
        y1 <= y;
      end
    end
  end

  heaa_ed_calc #(
    .N (N),
    .P (P)
  ) u_ed (
    .x  (x1),
    .y  (y1),
    .ed (ed_c)
  );

  // S2: error distance register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed2 <= '0;
      v2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) ed2 <= ed_c;
    end
  end

`ifdef HEAA_MON_SAT_EN
  localparam int SW =
    ((ACC_W > EDW) ? ACC_W : EDW) + 1;
  localparam logic [SW-1:0] SMAX =
    SW'({ACC_W{1'b1}});
  logic [SW-1:0] tot;
  assign tot = SW'(sum_ed) + SW'(ed2);
  assign sum_nx = (tot > SMAX) ?
    {ACC_W{1'b1}} : tot[ACC_W-1:0];
`else
  assign sum_nx = sum_ed + ACC_W'(ed2);
`endif

  // S3: statistics, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (start_acc) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (v2) begin
      if (ed2 != '0) err_count <= err_count + CW'(1);
      if (ed2 > max_ed) max_ed <= ed2;
      sum_ed <= sum_nx;
    end
  end

endmodule

// File: tb/tb_heaa_err_monitor.sv
// tb_heaa_err_monitor: scoreboard bench for heaa_err_monitor.
// Second instance uses ACC_W=4 for wrap/saturation.
module tb_heaa_err_monitor;

  localparam int TN = 16;
  localparam int TP = 7;

  typedef struct packed {
    logic [15:0] e;
    logic [31:0] s;
    logic [16:0] m;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic        busy, done;
  logic [15:0] err_count;
  logic [31:0] sum_ed;
  logic [16:0] max_ed;

  logic        in_ready4, busy4, done4;
  logic [15:0] err4;
  logic [3:0]  sum4;
  logic [16:0] max4;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  heaa_err_monitor #(
    .N(TN), .P(TP), .CW(16), .ACC_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .busy(busy), .done(done),
    .err_count(err_count), .sum_ed(sum_ed),
    .max_ed(max_ed)
  );

  heaa_err_monitor #(
    .N(TN), .P(TP), .CW(16), .ACC_W(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready4),
    .x(x), .y(y), .busy(busy4), .done(done4),
    .err_count(err4), .sum_ed(sum4),
    .max_ed(max4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_ed(
    input logic [15:0] a,
    input logic [15:0] b
  );
    int unsigned ua, ub, ex, ap, lo, c, lm;
    ua = a;
    ub = b;
    lm = (32'd1 << (TP - 1)) - 1;
    ex = ua + ub;
    c  = (ua >> (TP - 1)) & (ub >> (TP - 1)) & 1;
    lo = ((ua | ub) & lm) |
         ((((ua ^ ub) >> (TP - 1)) & 1) << (TP - 1));
    ap = (((ua >> TP) + (ub >> TP) + c) << TP) | lo;
    return 17'((ap > ex) ? ap - ex : ex - ap);
  endfunction

  task automatic push_exp(
    input logic [15:0] e,
    input logic [31:0] s,
    input logic [16:0] m
  );
    exp_t t;
    t.e = e;
    t.s = s;
    t.m = m;
    sb.push_back(t);
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(
    input logic [15:0] a,
    input logic [15:0] b
  );
    int g;
    g = 0;
    in_valid = 1'b1;
    x = a;
    y = b;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got=%0b want=1",
               in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(
    input string nm,
    output int lat
  );
    exp_t e;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got=%0b want=1",
               nm, done);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty got=0 want=1", nm);
    end else begin
      e = sb.pop_front();
      if (err_count !== e.e) begin
        errors++;
        $display("FAIL %s_err got=%0d want=%0d",
                 nm, err_count, e.e);
      end
      checks++;
      if (sum_ed !== e.s) begin
        errors++;
        $display("FAIL %s_sum got=%0d want=%0d",
                 nm, sum_ed, e.s);
      end
      checks++;
      if (max_ed !== e.m) begin
        errors++;
        $display("FAIL %s_max got=%0d want=%0d",
                 nm, max_ed, e.m);
      end
    end
  endtask

  task automatic chk_idle_zero(input string nm);
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s_ctl got=%b want=000",
               nm, {in_ready, busy, done});
    end
    checks++;
    if (err_count !== 16'd0 || sum_ed !== 32'd0 ||
        max_ed !== 17'd0) begin
      errors++;
      $display("FAIL %s_stats got=%0d/%0d/%0d want=0/0/0",
               nm, err_count, sum_ed, max_ed);
    end
  endtask

  task automatic test_reset();
    chk_idle_zero("reset");
  endtask

  task automatic test_first();
    int lat;
    do_start(16'd1);
    send(16'h007F, 16'h0001);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_drain got=%b want=01",
               {in_ready, busy});
    end
    push_exp(16'd1, 32'd1, 17'd1);
    wait_done("first", lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL first_latency got=%0d want=3", lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL first_busy got=%0b want=0", busy);
    end
  endtask

  task automatic test_exact();
    int lat;
    do_start(16'd1);
    send(16'h0040, 16'h0040);
    push_exp(16'd0, 32'd0, 17'd0);
    wait_done("exact", lat);
  endtask

  task automatic test_stall();
    int lat;
    do_start(16'd3);
    send(16'h0003, 16'h0003);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_ready got=%0b want=1",
                 in_ready);
      end
      @(negedge clk);
    end
    send(16'hFFFF, 16'h0001);
    send(16'h0000, 16'h0000);
    push_exp(16'd2, 32'd4, 17'd3);
    wait_done("stall", lat);
  endtask

  task automatic test_zero();
    int lat;
    do_start(16'd0);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got=%b want=10",
               {done, in_ready});
    end
    push_exp(16'd0, 32'd0, 17'd0);
    wait_done("zero", lat);
  endtask

  task automatic test_ignore();
    int lat;
    do_start(16'd2);
    send(16'h0003, 16'h0003);
    do_start(16'd5);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy got=%b want=10",
               {busy, done});
    end
    send(16'h0006, 16'h0006);
    push_exp(16'd2, 32'd9, 17'd6);
    wait_done("ignore", lat);
  endtask

  task automatic test_sat();
    int lat;
    logic [3:0] want4;
    do_start(16'd4);
    for (int i = 0; i < 4; i++) send(16'h0006, 16'h0006);
    push_exp(16'd4, 32'd24, 17'd6);
    wait_done("sat", lat);
`ifdef HEAA_MON_SAT_EN
    want4 = 4'd15;
`else
    want4 = 4'd8;
`endif
    checks++;
    if (sum4 !== want4) begin
      errors++;
      $display("FAIL sat_sum4 got=%0d want=%0d",
               sum4, want4);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] a, b;
    logic [16:0] d, mx;
    logic [15:0] ec;
    logic [31:0] sm;
    ec = '0;
    sm = '0;
    mx = '0;
    do_start(16'd6);
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      d = model_ed(a, b);
      if (d != 0) ec = ec + 16'd1;
      sm = sm + 32'(d);
      if (d > mx) mx = d;
      send(a, b);
    end
    push_exp(ec, sm, mx);
    wait_done("random", lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    do_start(16'd3);
    send(16'h007F, 16'h0001);
    send(16'h0003, 16'h0003);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(16'd1);
    send(16'h007F, 16'h0001);
    push_exp(16'd1, 32'd1, 17'd1);
    wait_done("postreset", lat);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_first();
    test_exact();
    test_stall();
    test_zero();
    test_ignore();
    test_sat();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
